// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS datapath and controller:
// opcodes, func codes, state encodings and datapath mux/ALU select codes.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_ALUWB = 4'd3,
    S_MA    = 4'd4,
    S_MEM   = 4'd5,
    S_MWB   = 4'd6,
    S_BR    = 4'd7,
    S_JAL   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_RA   = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_LUI = 2'b01;
  localparam logic [1:0] M2R_MEM = 2'b10;
  localparam logic [1:0] M2R_PC4 = 2'b11;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JAL = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // One-hot instruction class; all-zero means NOP.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic ori;
    logic jal;
  } insn_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decode into a one-hot instruction class.
// Unrecognised encodings produce an all-zero class (NOP).
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output insn_cls_t  cls
);

  always_comb begin
    cls = '0;
    unique case (op)
      OP_RTYPE: begin
        cls.addu = (func == FN_ADDU);
        cls.subu = (func == FN_SUBU);
        cls.jr   = (func == FN_JR);
      end
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_ORI:  cls.ori = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS controller: state register plus Moore output decode from
// state and current op/func. S_MEM stalls until mem_ready.
module mc_controller
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] NPCOp,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [2:0] ALUCtrl,
  output logic       MemReq,
  output logic       MemWrite,
  output logic [3:0] state
);

  state_t    state_q, state_d;
  insn_cls_t cls;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .cls  (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Unlisted or unreachable encodings fall through to S_IF.
  always_comb begin
    state_d = S_IF;
    unique case (state_q)
      S_IF:  state_d = S_DCD;
      S_DCD: begin
        if (cls.addu || cls.subu || cls.ori || cls.lui) state_d = S_EXE;
        else if (cls.lw || cls.sw)                      state_d = S_MA;
        else if (cls.beq)                               state_d = S_BR;
        else if (cls.jal)                               state_d = S_JAL;
        else                                            state_d = S_IF;
      end
      S_EXE:   state_d = S_ALUWB;
      S_ALUWB: state_d = S_IF;
      S_MA:    state_d = S_MEM;
      S_MEM: begin
        if (!mem_ready)  state_d = S_MEM;
        else if (cls.lw) state_d = S_MWB;
        else             state_d = S_IF;
      end
      S_MWB:   state_d = S_IF;
      S_BR:    state_d = S_IF;
      S_JAL:   state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    NPCOp    = NPC_PC4;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = RD_RT;
    MemtoReg = M2R_ALU;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUCtrl  = ALU_PASS;
    MemReq   = 1'b0;
    MemWrite = 1'b0;
    unique case (state_q)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_DCD: begin
        if (cls.jr) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JR;
        end
      end
      S_EXE: begin
        if (cls.addu) begin
          ALUCtrl = ALU_ADD;
        end else if (cls.subu) begin
          ALUCtrl = ALU_SUB;
        end else if (cls.ori) begin
          ALUCtrl = ALU_OR;
          ALUSrc  = 1'b1;
          ExtOp   = 1'b1;
        end
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        if (cls.addu || cls.subu) RegDst = RD_RD;
        if (cls.lui)              MemtoReg = M2R_LUI;
      end
      S_MA: begin
        ALUCtrl = ALU_ADD;
        ALUSrc  = 1'b1;
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemWrite = cls.sw;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MEM;
      end
      S_BR: begin
        ALUCtrl = ALU_SUB;
        NPCOp   = NPC_BR;
        PCWrite = zero;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        RegDst   = RD_RA;
        MemtoReg = M2R_PC4;
        PCWrite  = 1'b1;
        NPCOp    = NPC_JAL;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-state output checks at the falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic [1:0] NPCOp;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrc;
  logic       ExtOp;
  logic [2:0] ALUCtrl;
  logic       MemReq;
  logic       MemWrite;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] T_IF = 4'd0, T_DCD = 4'd1, T_EXE = 4'd2, T_ALUWB = 4'd3,
                         T_MA = 4'd4, T_MEM = 4'd5, T_MWB = 4'd6, T_BR = 4'd7,
                         T_JAL = 4'd8;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .func      (func),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .NPCOp     (NPCOp),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .ALUSrc    (ALUSrc),
    .ExtOp     (ExtOp),
    .ALUCtrl   (ALUCtrl),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, PCWrite, IRWrite, RegWrite, MemWrite};
  endfunction

  initial begin
    int cyc;
    int req_cnt;
    bit saw_mwb;

    reset = 1'b1; op = 6'b111111; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_state",   32'(state), 32'(T_IF));
    chk("rst_strobes", strobes(), 32'b1100);
    chk("rst_npc",     32'(NPCOp), 32'd0);
    chk("rst_memreq",  32'(MemReq), 32'd0);
    chk("rst_aluctrl", 32'(ALUCtrl), 32'b111);
    @(negedge clk);
    reset = 1'b0;

    // addu
    op = 6'b000000; func = 6'b100001;
    chk("addu_if", 32'(state), 32'(T_IF));
    tick();
    chk("addu_dcd", 32'(state), 32'(T_DCD));
    chk("addu_dcd_rw", 32'(RegWrite), 32'd0);
    tick();
    chk("addu_exe", 32'(state), 32'(T_EXE));
    chk("addu_exe_alu", 32'({ALUCtrl, ALUSrc}), 32'b0100);
    chk("addu_exe_rw", 32'(RegWrite), 32'd0);
    tick();
    chk("addu_wb", 32'(state), 32'(T_ALUWB));
    chk("addu_wb_ctl", 32'({RegWrite, RegDst, MemtoReg}), 32'b10100);
    tick();
    chk("addu_back_if", 32'(state), 32'(T_IF));
    chk("addu_if_rw", 32'(RegWrite), 32'd0);

    // subu / ori / lui EXE and WB encodings
    func = 6'b100011;
    tick(); tick();
    chk("subu_exe_alu", 32'({ALUCtrl, ALUSrc}), 32'b0110);
    tick(); tick();
    op = 6'b001101;
    tick(); tick();
    chk("ori_exe", 32'({ALUCtrl, ALUSrc, ExtOp}), 32'b00111);
    tick();
    chk("ori_wb", 32'({RegWrite, RegDst, MemtoReg}), 32'b10000);
    tick();
    op = 6'b001111;
    tick(); tick();
    chk("lui_exe", 32'({ALUCtrl, ALUSrc, ExtOp}), 32'b11100);
    tick();
    chk("lui_wb", 32'({RegWrite, RegDst, MemtoReg}), 32'b10001);
    tick();

    // lw with three not-ready cycles; mem_ready high outside S_MEM must be ignored
    op = 6'b100011; func = 6'd0;
    cyc = 0; req_cnt = 0; saw_mwb = 0;
    chk("lw_if", 32'(state), 32'(T_IF));
    for (int i = 0; i < 20; i++) begin
      if (state == T_MA) chk("lw_ma", 32'({ALUCtrl, ALUSrc, ExtOp}), 32'b01010);
      if (state == T_MEM) begin
        req_cnt++;
        chk("lw_mem_wr", 32'(MemWrite), 32'd0);
      end
      if (state == T_MWB) begin
        saw_mwb = 1;
        chk("lw_mwb", 32'({RegWrite, RegDst, MemtoReg}), 32'b10010);
      end
      mem_ready = (state == T_MEM) ? (req_cnt >= 4) : (state == T_DCD);
      chk("lw_memreq", 32'(MemReq), 32'(state == T_MEM));
      tick();
      cyc++;
      if (state == T_IF) break;
    end
    mem_ready = 1'b0;
    chk("lw_cycles", 32'(cyc), 32'd8);
    chk("lw_req_cnt", 32'(req_cnt), 32'd4);
    chk("lw_saw_mwb", 32'(saw_mwb), 32'd1);

    // beq taken, then not taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick();
    chk("beq1_state", 32'(state), 32'(T_BR));
    chk("beq1_ctl", 32'({PCWrite, NPCOp, ALUCtrl}), 32'b101011);
    tick();
    chk("beq1_back", 32'(state), 32'(T_IF));
    zero = 1'b0;
    tick(); tick();
    chk("beq0_state", 32'(state), 32'(T_BR));
    chk("beq0_pcw", 32'(PCWrite), 32'd0);
    tick();

    // jal
    op = 6'b000011;
    tick(); tick();
    chk("jal_state", 32'(state), 32'(T_JAL));
    chk("jal_ctl", 32'({RegWrite, RegDst, MemtoReg, PCWrite, NPCOp}), 32'b11011110);
    tick();
    chk("jal_back", 32'(state), 32'(T_IF));

    // jr
    op = 6'b000000; func = 6'b001000;
    tick();
    chk("jr_dcd", 32'(state), 32'(T_DCD));
    chk("jr_ctl", 32'({PCWrite, NPCOp, RegWrite}), 32'b1110);
    tick();
    chk("jr_back", 32'(state), 32'(T_IF));

    // sw interrupted by reset during the memory wait
    op = 6'b101011; func = 6'd0;
    tick(); tick(); tick();
    chk("sw_mem", 32'(state), 32'(T_MEM));
    chk("sw_req", 32'({MemReq, MemWrite}), 32'b11);
    tick();
    chk("sw_hold", 32'(state), 32'(T_MEM));
    #2 reset = 1'b1;
    #1;
    chk("sw_rst_state", 32'(state), 32'(T_IF));
    chk("sw_rst_req", 32'({MemReq, MemWrite}), 32'b00);
    chk("sw_rst_strobes", strobes(), 32'b1100);
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 1);
      @(negedge clk);
      chk("sw_rst_nowr", 32'({MemReq, MemWrite}), 32'b00);
    end
    mem_ready = 1'b0;
    op = 6'b111111;
    reset = 1'b0;

    // illegal opcode
    chk("ill_if", 32'(state), 32'(T_IF));
    tick();
    chk("ill_dcd", 32'(state), 32'(T_DCD));
    chk("ill_dcd_strobes", strobes(), 32'd0);
    chk("ill_dcd_req", 32'({MemReq, NPCOp}), 32'd0);
    tick();
    chk("ill_back", 32'(state), 32'(T_IF));
    chk("ill_nowr", 32'({MemWrite, RegWrite}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
